// File: rtl/amoled_pkg.sv
// Shared definitions for the AMOLED row sequencer: sequencing phases and
// nominal phase durations in clock cycles.
package amoled_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        PROG = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam int unsigned T_INIT = 2000;
    localparam int unsigned T_PROG = 3000;
    localparam int unsigned T_GAP  = 5000;

endpackage

// File: rtl/amoled_phase_timer.sv
// Loadable down-counter that times one sequencing phase; done_c is high
// during the last cycle of the loaded duration.
module amoled_phase_timer #(
    parameter int unsigned CW = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done_c
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done_c = (cnt == CW'(1));

endmodule

// File: rtl/amoled_row_sequencer.sv
// Sequences INIT/PROG/GAP phases row by row across an AMOLED panel and keeps
// per-row emission enables so programmed rows continue to emit between frames.
module amoled_row_sequencer
    import amoled_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned CW   = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     cont,
    input  logic                     stop,
    input  logic                     blank,
    input  logic [CW-1:0]            t_init,
    input  logic [CW-1:0]            t_prog,
    input  logic [CW-1:0]            t_gap,
    output logic [ROWS-1:0]          vinit,
    output logic [ROWS-1:0]          vcomp,
    output logic [ROWS-1:0]          vscan,
    output logic [ROWS-1:0]          vem,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned RW = $clog2(ROWS);

    state_e          state, state_nx;
    logic [RW-1:0]   row_nx;
    logic [ROWS-1:0] em_en, em_nx;
    logic            stop_pend, pend_nx;
    logic [CW-1:0]   sh_init, sh_prog, sh_gap;
    logic            sh_cont;
    logic            load_c;
    logic [CW-1:0]   load_val_c;
    logic            done_c;
    logic [ROWS-1:0] vinit_nx, vcomp_nx, vscan_nx, vem_nx;
    logic            fd_nx;

    // A zero duration still occupies one cycle.
    function automatic logic [CW-1:0] sat_dur(input logic [CW-1:0] t);
        return (t == '0) ? CW'(1) : t;
    endfunction

    amoled_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .load_val (load_val_c),
        .done_c   (done_c)
    );

    // Next-state, timer control and next values of all registered outputs.
    always_comb begin
        state_nx   = state;
        row_nx     = row_idx;
        em_nx      = em_en;
        pend_nx    = stop_pend;
        load_c     = 1'b0;
        load_val_c = sh_init;
        fd_nx      = 1'b0;
        vinit_nx   = '0;
        vcomp_nx   = '0;
        vscan_nx   = '0;

        if (state != IDLE && stop) begin
            pend_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                pend_nx = 1'b0;
                if (start) begin
                    state_nx   = INIT;
                    row_nx     = '0;
                    load_c     = 1'b1;
                    load_val_c = sat_dur(t_init);
                    em_nx[0]   = 1'b0;
                end
            end
            INIT: begin
                if (done_c) begin
                    state_nx   = PROG;
                    load_c     = 1'b1;
                    load_val_c = sh_prog;
                end
            end
            PROG: begin
                if (done_c) begin
                    state_nx       = GAP;
                    load_c         = 1'b1;
                    load_val_c     = sh_gap;
                    em_nx[row_idx] = 1'b1;
                end
            end
            GAP: begin
                if (done_c) begin
                    load_val_c = sh_init;
                    if (row_idx == RW'(ROWS - 1)) begin
                        fd_nx   = 1'b1;
                        row_nx  = '0;
                        pend_nx = 1'b0;
                        if (sh_cont && !(stop_pend || stop)) begin
                            state_nx = INIT;
                            load_c   = 1'b1;
                            em_nx[0] = 1'b0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        row_nx        = row_idx + RW'(1);
                        state_nx      = INIT;
                        load_c        = 1'b1;
                        em_nx[row_nx] = 1'b0;
                    end
                end
            end
        endcase

        if (state_nx == INIT) begin
            vinit_nx[row_nx] = 1'b1;
            vcomp_nx[row_nx] = 1'b1;
        end else if (state_nx == PROG) begin
            vscan_nx[row_nx] = 1'b1;
            vcomp_nx[row_nx] = 1'b1;
        end
        vem_nx = em_nx & ~{ROWS{blank}};
    end

    // State, control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            row_idx    <= '0;
            em_en      <= '0;
            stop_pend  <= 1'b0;
            sh_init    <= '0;
            sh_prog    <= '0;
            sh_gap     <= '0;
            sh_cont    <= 1'b0;
            vinit      <= '0;
            vcomp      <= '0;
            vscan      <= '0;
            vem        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            row_idx    <= row_nx;
            em_en      <= em_nx;
            stop_pend  <= pend_nx;
            vinit      <= vinit_nx;
            vcomp      <= vcomp_nx;
            vscan      <= vscan_nx;
            vem        <= vem_nx;
            busy       <= (state_nx != IDLE);
            frame_done <= fd_nx;
            if (state == IDLE && start) begin
                sh_init <= sat_dur(t_init);
                sh_prog <= sat_dur(t_prog);
                sh_gap  <= sat_dur(t_gap);
                sh_cont <= cont;
            end
        end
    end

endmodule

// File: doc/amoled_row_sequencer.md
AMOLED_ROW_SEQUENCER -- requirements
Module: amoled_row_sequencer

Interface
REQ-001 Parameter ROWS, default 8, number of panel rows driven (2..64).
REQ-002 Parameter CW, default 17, width of all phase-duration counters and config fields.
REQ-003 clk  input  1  system clock, 100 MHz (10 ns).
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a frame; honoured only in IDLE.
REQ-006 cont  input  1  sampled at start: 1 = repeat frames back-to-back, 0 = single frame.
REQ-007 stop  input  1  single-cycle request: finish the current frame, then return to IDLE.
REQ-008 blank  input  1  level; forces all vem low while high.
REQ-009 t_init, t_prog, t_gap  input  CW each  durations in cycles of INIT, PROG and inter-row GAP phases.
REQ-010 vinit, vcomp, vscan, vem  output  ROWS each  per-row panel control lines, all registered.
REQ-011 row_idx  output  $clog2(ROWS)  row currently being sequenced.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 frame_done  output  1  single-cycle pulse at the end of each frame.

Function
REQ-014 FSM states: IDLE, INIT, PROG, GAP; only one row is in INIT or PROG at any time.
REQ-015 IDLE + start -> INIT with row_idx=0; t_init/t_prog/t_gap/cont latched into shadow registers on the same edge.
REQ-016 Config inputs changing while busy have no effect until the next accepted start.
REQ-017 start while busy is ignored.
REQ-018 Duration value 0 is treated as 1; each phase lasts exactly max(t,1) cycles.
REQ-019 INIT: vinit[row_idx]=1, vcomp[row_idx]=1, vem[row_idx]=0.
REQ-020 PROG: vscan[row_idx]=1, vcomp[row_idx]=1, vem[row_idx]=0.
REQ-021 GAP: all vinit/vcomp/vscan low; the just-programmed row's emission-enable bit is set on GAP entry.
REQ-022 On INIT entry for row r, emission-enable bit r is cleared; all other bits hold.
REQ-023 vem[r] = emission-enable[r] AND NOT blank, registered (one-cycle latency from blank).
REQ-024 GAP end, row_idx < ROWS-1: row_idx+1, -> INIT.
REQ-025 GAP end, row_idx = ROWS-1: frame_done pulses; row_idx wraps to 0; -> INIT if cont=1 and no stop pending, else -> IDLE.
REQ-026 stop is latched as pending until frame end; stop while IDLE is discarded.
REQ-027 stop and start in the same IDLE cycle: start wins, stop discarded.
REQ-028 In IDLE the emission-enable bits hold, so rows keep emitting the last frame.
REQ-029 Output lines of rows other than row_idx are never asserted for vinit/vcomp/vscan.
REQ-030 Frame length is ROWS*(max(t_init,1)+max(t_prog,1)+max(t_gap,1)) cycles.

Reset
REQ-031 Reset asserted: state=IDLE; row_idx=0; all vinit/vcomp/vscan/vem=0; busy=0; frame_done=0; emission-enable=0; stop-pending cleared; shadow config=0.
REQ-032 Reset mid-frame aborts immediately with no frame_done pulse; the first start after release begins a frame at row 0.

Structure
REQ-033 State encoding and phase enum belong in a shared package amoled_pkg, with default durations T_INIT=2000, T_PROG=3000, T_GAP=5000.
REQ-034 One sub-module, amoled_phase_timer (loadable down-counter, CW bits, done pulse), times every phase.

Verification
REQ-035 ROWS=4, t_init=2, t_prog=3, t_gap=1, cont=0, start -> rows 0..3 each show vinit+vcomp for 2 cycles then vscan+vcomp for 3; frame_done once at cycle 24; busy low after.
REQ-036 cont=1 then stop at cycle 10 -> frame 1 completes, frame_done at 24, IDLE; no second frame.
REQ-037 t_init=0, t_prog=0, t_gap=0 -> each phase lasts 1 cycle; frame length 3*ROWS.
REQ-038 blank high for 5 cycles after frame 1 -> all vem low for 5 cycles starting one cycle later, then restored.
REQ-039 Reset asserted mid-PROG of row 2 -> all outputs 0 asynchronously, no frame_done; next start sequences row 0 first.
REQ-040 start pulsed again and t_prog changed during a frame -> no restart; timing unchanged until next frame.
